// File: rtl/fifo_sync_flex.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// threshold flags and flush. Define FIFO_ERR_FLAGS_EN to add sticky OVFo/UDFo.
module fifo_sync_flex #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned AF_THRESH  = FIFO_DEPTH - 2,
    parameter int unsigned AE_THRESH  = 2,
    parameter int unsigned FWFT       = 0,
    parameter int unsigned LOG2_DEPTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  CLKip,
    input  logic                  RSTi,
    input  logic                  FLUSHi,
    input  logic                  WEi,
    input  logic [DATA_WIDTH-1:0] DATAi,
    input  logic                  RDi,
    output logic [DATA_WIDTH-1:0] DATAo,
    output logic                  FULLo,
    output logic                  EMPTYo,
    output logic                  AFULLo,
    output logic                  AEMPTYo,
`ifdef FIFO_ERR_FLAGS_EN
    output logic                  OVFo,
    output logic                  UDFo,
`endif
    output logic [LOG2_DEPTH:0]   LEVELo
);

    localparam int unsigned LW = LOG2_DEPTH + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [LOG2_DEPTH-1:0] rd_ptr;
    logic [LW-1:0]         level;
    logic                  wr_ok;
    logic                  rd_ok;

    assign wr_ok   = WEi && !FULLo;
    assign rd_ok   = RDi && !EMPTYo;

    // Status is decoded straight from the registered occupancy.
    assign FULLo   = (level == LW'(FIFO_DEPTH));
    assign EMPTYo  = (level == LW'(0));
    assign AFULLo  = (level >= LW'(AF_THRESH));
    assign AEMPTYo = (level <= LW'(AE_THRESH));
    assign LEVELo  = level;

    always_ff @(posedge CLKip or negedge RSTi) begin
        if (!RSTi) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (FLUSHi) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
            if (rd_ok) rd_ptr <= rd_ptr + LOG2_DEPTH'(1);
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage is not reset; writes are blocked during reset and flush.
    always_ff @(posedge CLKip) begin
        if (RSTi && !FLUSHi && wr_ok) mem[wr_ptr] <= DATAi;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign DATAo = mem[rd_ptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout;
            always_ff @(posedge CLKip or negedge RSTi) begin
                if (!RSTi) begin
                    dout <= '0;
                end else if (!FLUSHi && rd_ok) begin
                    dout <= mem[rd_ptr];
                end
            end
            assign DATAo = dout;
        end
    endgenerate

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky illegal-request flags, cleared only by flush or reset.
    always_ff @(posedge CLKip or negedge RSTi) begin
        if (!RSTi) begin
            OVFo <= 1'b0;
            UDFo <= 1'b0;
        end else if (FLUSHi) begin
            OVFo <= 1'b0;
            UDFo <= 1'b0;
        end else begin
            if (WEi && FULLo)  OVFo <= 1'b1;
            if (RDi && EMPTYo) UDFo <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Bench for fifo_sync_flex: standard and FWFT instances share stimulus and are
// checked against a queue-based reference model.
module tb_fifo_sync_flex;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;

    logic          CLKip = 1'b0;
    logic          RSTi;
    logic          FLUSHi;
    logic          WEi;
    logic          RDi;
    logic [DW-1:0] DATAi;

    logic [DW-1:0] dout_s, dout_f;
    logic          full_s, empty_s, afull_s, aempty_s;
    logic          full_f, empty_f, afull_f, aempty_f;
    logic [4:0]    level_s, level_f;
`ifdef FIFO_ERR_FLAGS_EN
    logic          ovf_s, udf_s, ovf_f, udf_f;
`endif

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_ovf;
    logic          m_udf;

    always #5 CLKip = ~CLKip;

    fifo_sync_flex #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(0)) u_std (
        .CLKip(CLKip), .RSTi(RSTi), .FLUSHi(FLUSHi), .WEi(WEi), .DATAi(DATAi), .RDi(RDi),
        .DATAo(dout_s), .FULLo(full_s), .EMPTYo(empty_s), .AFULLo(afull_s), .AEMPTYo(aempty_s),
`ifdef FIFO_ERR_FLAGS_EN
        .OVFo(ovf_s), .UDFo(udf_s),
`endif
        .LEVELo(level_s)
    );

    fifo_sync_flex #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .CLKip(CLKip), .RSTi(RSTi), .FLUSHi(FLUSHi), .WEi(WEi), .DATAi(DATAi), .RDi(RDi),
        .DATAo(dout_f), .FULLo(full_f), .EMPTYo(empty_f), .AFULLo(afull_f), .AEMPTYo(aempty_f),
`ifdef FIFO_ERR_FLAGS_EN
        .OVFo(ovf_f), .UDFo(udf_f),
`endif
        .LEVELo(level_f)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        int lvl;
        lvl = q.size();
        check({tag, " level_s"},  32'(level_s),  32'(lvl));
        check({tag, " level_f"},  32'(level_f),  32'(lvl));
        check({tag, " full_s"},   32'(full_s),   32'(lvl == DEPTH));
        check({tag, " full_f"},   32'(full_f),   32'(lvl == DEPTH));
        check({tag, " empty_s"},  32'(empty_s),  32'(lvl == 0));
        check({tag, " empty_f"},  32'(empty_f),  32'(lvl == 0));
        check({tag, " afull_s"},  32'(afull_s),  32'(lvl >= DEPTH - 2));
        check({tag, " afull_f"},  32'(afull_f),  32'(lvl >= DEPTH - 2));
        check({tag, " aempty_s"}, 32'(aempty_s), 32'(lvl <= 2));
        check({tag, " aempty_f"}, 32'(aempty_f), 32'(lvl <= 2));
        check({tag, " dout_s"},   32'(dout_s),   32'(m_dout));
        if (lvl != 0) check({tag, " dout_f"}, 32'(dout_f), 32'(q[0]));
`ifdef FIFO_ERR_FLAGS_EN
        check({tag, " ovf_s"}, 32'(ovf_s), 32'(m_ovf));
        check({tag, " udf_s"}, 32'(udf_s), 32'(m_udf));
        check({tag, " ovf_f"}, 32'(ovf_f), 32'(m_ovf));
        check({tag, " udf_f"}, 32'(udf_f), 32'(m_udf));
`endif
    endtask

    // One clock: drive, advance the model by the FIFO rules, then compare.
    task automatic step(input string tag, input logic we, input logic [DW-1:0] din,
                        input logic rd, input logic flush);
        bit full, empty;
        WEi = we; DATAi = din; RDi = rd; FLUSHi = flush;
        @(posedge CLKip);
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        if (flush) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (we && full)  m_ovf = 1'b1;
            if (rd && empty) m_udf = 1'b1;
            if (rd && !empty) m_dout = q.pop_front();
            if (we && !full)  q.push_back(din);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        RSTi = 1'b0; FLUSHi = 1'b0; WEi = 1'b0; RDi = 1'b0; DATAi = '0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge CLKip);
        RSTi = 1'b1;

        // Basic ordering and one-cycle read latency in standard mode
        step("w11", 1, 8'h11, 0, 0);
        step("w22", 1, 8'h22, 0, 0);
        step("w33", 1, 8'h33, 0, 0);
        check("lvl3", 32'(level_s), 32'd3);
        step("r1", 0, 8'h00, 1, 0);
        check("rd 11", 32'(dout_s), 32'h11);
        step("r2", 0, 8'h00, 1, 0);
        check("rd 22", 32'(dout_s), 32'h22);
        step("r3", 0, 8'h00, 1, 0);
        check("rd 33", 32'(dout_s), 32'h33);
        check("empty end", 32'(empty_s), 32'd1);

        // Fill to full, overflow attempt, then simultaneous op at full
        for (int i = 0; i < 16; i++) step("fill", 1, DW'(i), 0, 0);
        check("full", 32'(full_s), 32'd1);
        step("ovf write", 1, 8'hAA, 0, 0);
        check("full lvl", 32'(level_s), 32'd16);
        step("wr+rd full", 1, 8'h55, 1, 0);
        check("rd 00", 32'(dout_s), 32'h00);
        check("lvl15", 32'(level_s), 32'd15);
        for (int i = 1; i < 16; i++) begin
            step("drain", 0, 8'h00, 1, 0);
            check("drain data", 32'(dout_s), 32'(i));
        end

        // Simultaneous op at empty: read is rejected, DATAo holds
        step("wr+rd empty", 1, 8'h66, 1, 0);
        check("hold 0f", 32'(dout_s), 32'h0F);
        check("lvl1", 32'(level_s), 32'd1);
        step("udf read", 0, 8'h00, 1, 0);
        step("udf read2", 0, 8'h00, 1, 0);

        // Pointer wrap at constant level 5
        for (int i = 0; i < 5; i++) step("pre5", 1, DW'($urandom), 0, 0);
        for (int i = 0; i < 40; i++) step("wrap", 1, DW'($urandom), 1, 0);
        check("wrap lvl5", 32'(level_s), 32'd5);

        // FWFT: written word appears without a read
        step("flush", 0, 8'h00, 0, 1);
        step("fw 7e", 1, 8'h7E, 0, 0);
        check("fwft 7e", 32'(dout_f), 32'h7E);
        check("fwft nempty", 32'(empty_f), 32'd0);
        step("fw 7f", 1, 8'h7F, 0, 0);
        step("fw pop", 0, 8'h00, 1, 0);
        check("fwft 7f", 32'(dout_f), 32'h7F);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 99) < 55), DW'($urandom),
                 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 2));
        end

        // Flush at level 9 with a concurrent write
        step("flush0", 0, 8'h00, 0, 1);
        for (int i = 0; i < 9; i++) step("to9", 1, DW'(8'hC0 + i), 0, 0);
        check("lvl9", 32'(level_s), 32'd9);
        step("flush9", 1, 8'hEE, 0, 1);
        check("flush lvl", 32'(level_s), 32'd0);
        check("flush aempty", 32'(aempty_s), 32'd1);

        // Asynchronous reset in the middle of a write burst
        for (int i = 0; i < 6; i++) step("burst", 1, DW'($urandom), 0, 0);
        #2;
        RSTi = 1'b0;
        #1;
        model_reset();
        check_all("async rst");
        @(posedge CLKip);
        #1;
        check_all("rst held");
        @(negedge CLKip);
        RSTi = 1'b1;
        step("post rst", 0, 8'h00, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_sync_flex.md
Name: fifo_sync_flex

Overview:
- Parametrised single-clock FIFO; next generation of the UART receiver's synchronous buffer.
- Generalised in data width and depth.
- Adds selectable first-word-fall-through (FWFT) read mode, almost-full/almost-empty thresholds, an occupancy output and synchronous flush.
- Sits between the UART RX byte assembler and the system-side consumer; also reusable on the TX path.

Parameters:
DATA_WIDTH, 8, data word width in bits (>=1)
FIFO_DEPTH, 16, number of entries; power of 2, >=2
AF_THRESH, FIFO_DEPTH-2, AFULLo asserted when level >= AF_THRESH
AE_THRESH, 2, AEMPTYo asserted when level <= AE_THRESH
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
LOG2_DEPTH, $clog2(FIFO_DEPTH), derived; do not override

Ports:
CLKip  input  1  clock, all logic on rising edge
RSTi  input  1  reset, asynchronous, active-low
FLUSHi  input  1  synchronous flush, priority over WEi/RDi
WEi  input  1  write request
DATAi  input  DATA_WIDTH  write data
RDi  input  1  read request / pop
DATAo  output  DATA_WIDTH  read data
FULLo  output  1  level == FIFO_DEPTH
EMPTYo  output  1  level == 0
AFULLo  output  1  level >= AF_THRESH
AEMPTYo  output  1  level <= AE_THRESH
LEVELo  output  LOG2_DEPTH+1  current occupancy, 0..FIFO_DEPTH

Behaviour:
- Reset (RSTi low, async): wr_ptr = rd_ptr = level = 0; DATAo = 0 in standard mode. Outputs: EMPTYo=1, AEMPTYo=1, FULLo=0, AFULLo=0, LEVELo=0. Memory contents not reset.
- Write accepted iff WEi && !FULLo: mem[wr_ptr] <= DATAi; wr_ptr wraps modulo FIFO_DEPTH.
- Read accepted iff RDi && !EMPTYo; rd_ptr wraps modulo FIFO_DEPTH.
- Rejected requests have no effect on pointers, level or DATAo.
- Level update per edge:
  - +1 on write only; -1 on read only; unchanged when both or neither are accepted.
  - Full: write rejected, read accepted, level -> FIFO_DEPTH-1.
  - Empty: read rejected, write accepted, level -> 1.
- All flags and LEVELo are combinational from the registered level; they reflect an accepted op on the cycle after the edge.
- Standard mode (FWFT=0):
  - DATAo <= mem[rd_ptr] on an accepted read; visible 1 cycle after the RDi edge.
  - DATAo holds between reads.
- FWFT mode (FWFT=1):
  - DATAo = mem[rd_ptr] combinationally; valid whenever !EMPTYo.
  - A write into an empty FIFO is visible on DATAo, with EMPTYo=0, the cycle after the write edge.
  - RDi pops the head; the next word appears the following cycle.
  - DATAo is don't-care while EMPTYo=1. No reset value is required beyond the pointers.
- FLUSHi=1 at edge: pointers and level -> 0; concurrent WEi/RDi ignored. Standard mode DATAo holds its last value.
- Reset asserted mid-operation: immediate return to reset state regardless of pending requests.

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN.
- Defined:
  - Adds outputs OVFo and UDFo (1 bit each, reset 0).
  - OVFo sets on WEi && FULLo; UDFo sets on RDi && EMPTYo.
  - Both flags are sticky until FLUSHi or reset.
- Undefined:
  - Ports are absent; illegal requests are silently dropped as above.

Test Plan:
1. Defaults, standard mode: write 0x11,0x22,0x33; then RDi 3 cycles -> DATAo 0x11,0x22,0x33, each 1 cycle after its RDi edge; EMPTYo=1 at end; LEVELo 3 -> 0.
2. Fill 16 words 0x00..0x0F:
   - LEVELo=16, FULLo=1; AFULLo=1 from level 14.
   - Extra write 0xAA is dropped.
   - Draining returns 0x00..0x0F; OVFo=1 if FIFO_ERR_FLAGS_EN.
3. Level 16, simultaneous WEi(0x55)+RDi -> write rejected, LEVELo=15, FULLo=0. At level 0, simultaneous WEi(0x66)+RDi -> read rejected, LEVELo=1, DATAo unchanged.
4. Wrap-around: 40 interleaved write/read pairs at level 5 -> data order preserved across pointer wrap; LEVELo stays 5.
5. FWFT=1:
   - Write 0x7E into empty FIFO -> next cycle EMPTYo=0, DATAo=0x7E with no RDi.
   - Write 0x7F, then RDi -> DATAo=0x7F next cycle.
6. Level 9, FLUSHi with WEi=1 -> LEVELo=0, EMPTYo=1, AEMPTYo=1. Then assert RSTi low mid-burst -> all flags return to reset values asynchronously.
